// File: rtl/ncpu32k_ibus_resp.sv
// Instruction-bus responder: forwards IFU fetches to an in-order memory port and returns insns in order.
// Optional same-cycle response bypass to the IFU is enabled by defining NCPU_IBUS_RESP_BYPASS_EN.
module ncpu32k_ibus_resp #(
   parameter int            AW         = 32,
   parameter int            IW         = 32,
   parameter int            DEPTH      = 2,
   parameter logic [AW-1:0] RESET_ADDR = '0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          ibus_cmd_valid_i,
   output logic          ibus_cmd_ready_o,
   input  logic [AW-1:0] ibus_cmd_addr_i,
   input  logic          ibus_flush_req_i,
   output logic          ibus_valid_o,
   input  logic          ibus_ready_i,
   output logic [IW-1:0] ibus_dout_o,
   output logic [AW-1:0] ibus_out_id_o,
   output logic [AW-1:0] ibus_out_id_nxt_o,
   output logic          mem_cmd_valid_o,
   input  logic          mem_cmd_ready_i,
   output logic [AW-1:0] mem_cmd_addr_o,
   input  logic          mem_rsp_valid_i,
   input  logic [IW-1:0] mem_rsp_data_i
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [AW-1:0]    addr_q [DEPTH];
   logic [IW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   ptr_t             head_q, tail_q, fptr_q;
   ptr_t             head_d, tail_d, fptr_d;
   cnt_t             occ_q, unf_q, drop_q;
   cnt_t             occ_d, unf_d, drop_d;
   logic [AW-1:0]    out_id_nxt_q;
   logic             post_rst_q;

   logic [CW:0]      inflight;
   logic             credit_ok;
   logic             accept;
   logic             rsp_drop;
   logic             rsp_take;
   logic             rsp_err;
   logic             head_filled;
   logic             byp;
   logic             pop;

   // Handshakes: a transfer happens on a cycle where valid and ready are both high at the posedge.
   // Credit looks only at registered state, so a same-cycle pop never frees a slot for a push.
   assign inflight  = {1'b0, occ_q} + {1'b0, drop_q};
   assign credit_ok = inflight < (CW+1)'(DEPTH);

   assign mem_cmd_valid_o   = ibus_cmd_valid_i & credit_ok;
   assign ibus_cmd_ready_o  = mem_cmd_ready_i & credit_ok;
   assign mem_cmd_addr_o    = ibus_cmd_addr_i;
   assign accept            = ibus_cmd_valid_i & ibus_cmd_ready_o;
   assign ibus_out_id_nxt_o = out_id_nxt_q;

   assign rsp_drop    = mem_rsp_valid_i & (drop_q != '0);
   assign rsp_take    = mem_rsp_valid_i & (drop_q == '0) & (unf_q != '0);
   assign rsp_err     = mem_rsp_valid_i & (drop_q == '0) & (unf_q == '0);
   assign head_filled = (occ_q != '0) & filled_q[head_q];

`ifdef NCPU_IBUS_RESP_BYPASS_EN
   // No filled entry ahead means the responding entry is the head itself.
   assign byp          = rsp_take & (occ_q == unf_q);
   assign ibus_valid_o = head_filled | byp;
   assign ibus_dout_o  = byp ? mem_rsp_data_i : data_q[head_q];
`else
   assign byp          = 1'b0;
   assign ibus_valid_o = head_filled;
   assign ibus_dout_o  = data_q[head_q];
`endif
   assign ibus_out_id_o = addr_q[head_q];
   assign pop           = ibus_valid_o & ibus_ready_i;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      fptr_d = fptr_q;
      occ_d  = occ_q;
      unf_d  = unf_q;
      drop_d = drop_q;
      if (rsp_drop) begin
         drop_d = drop_q - cnt_t'(1);
      end
      if (rsp_take) begin
         unf_d  = unf_q - cnt_t'(1);
         fptr_d = fptr_q + ptr_t'(1);
      end
      if (pop) begin
         head_d = head_q + ptr_t'(1);
         occ_d  = occ_q - cnt_t'(1);
      end
      // Unfilled survivors still have responses coming back; those must be swallowed.
      if (ibus_flush_req_i) begin
         drop_d = drop_d + unf_d;
         head_d = tail_q;
         fptr_d = tail_q;
         occ_d  = '0;
         unf_d  = '0;
      end
      if (accept) begin
         tail_d = tail_q + ptr_t'(1);
         occ_d  = occ_d + cnt_t'(1);
         unf_d  = unf_d + cnt_t'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         filled_q     <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         fptr_q       <= '0;
         occ_q        <= '0;
         unf_q        <= '0;
         drop_q       <= '0;
         out_id_nxt_q <= RESET_ADDR - AW'(4);
         post_rst_q   <= 1'b1;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         fptr_q <= fptr_d;
         occ_q  <= occ_d;
         unf_q  <= unf_d;
         drop_q <= drop_d;
         if (rsp_take && !(byp && ibus_ready_i)) begin
            data_q[fptr_q]   <= mem_rsp_data_i;
            filled_q[fptr_q] <= 1'b1;
         end
         if (accept) begin
            addr_q[tail_q]   <= ibus_cmd_addr_i;
            filled_q[tail_q] <= 1'b0;
            out_id_nxt_q     <= ibus_cmd_addr_i;
            post_rst_q       <= 1'b0;
         end
      end
   end

`ifndef SYNTHESIS
   // Strays are tolerated only while requests issued before reset may still be draining.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(rsp_err && !post_rst_q));
      end
   end
`endif

endmodule

// File: tb/tb_ncpu32k_ibus_resp.sv
// Directed self-checking bench for ncpu32k_ibus_resp (default build, DEPTH=2, RESET_ADDR=0).
module tb_ncpu32k_ibus_resp;

   logic        clk;
   logic        rst;
   logic        ibus_cmd_valid;
   logic        ibus_cmd_ready;
   logic [31:0] ibus_cmd_addr;
   logic        ibus_flush_req;
   logic        ibus_valid;
   logic        ibus_ready;
   logic [31:0] ibus_dout;
   logic [31:0] ibus_out_id;
   logic [31:0] ibus_out_id_nxt;
   logic        mem_cmd_valid;
   logic        mem_cmd_ready;
   logic [31:0] mem_cmd_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   ncpu32k_ibus_resp #(
      .AW(32), .IW(32), .DEPTH(2), .RESET_ADDR(32'h0)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .ibus_cmd_valid_i  (ibus_cmd_valid),
      .ibus_cmd_ready_o  (ibus_cmd_ready),
      .ibus_cmd_addr_i   (ibus_cmd_addr),
      .ibus_flush_req_i  (ibus_flush_req),
      .ibus_valid_o      (ibus_valid),
      .ibus_ready_i      (ibus_ready),
      .ibus_dout_o       (ibus_dout),
      .ibus_out_id_o     (ibus_out_id),
      .ibus_out_id_nxt_o (ibus_out_id_nxt),
      .mem_cmd_valid_o   (mem_cmd_valid),
      .mem_cmd_ready_i   (mem_cmd_ready),
      .mem_cmd_addr_o    (mem_cmd_addr),
      .mem_rsp_valid_i   (mem_rsp_valid),
      .mem_rsp_data_i    (mem_rsp_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_idle();
      ibus_cmd_valid = 1'b0;
      ibus_cmd_addr  = '0;
      ibus_flush_req = 1'b0;
      ibus_ready     = 1'b0;
      mem_cmd_ready  = 1'b1;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   task automatic cmd(input logic v, input logic [31:0] a);
      ibus_cmd_valid = v;
      ibus_cmd_addr  = a;
   endtask

   task automatic rsp(input logic v, input logic [31:0] d);
      mem_rsp_valid = v;
      mem_rsp_data  = d;
   endtask

   initial begin
      logic        pend;
      logic [31:0] pend_addr;
      logic [31:0] next_addr;
      logic [31:0] a;
      int          delivered;

      rst = 1'b1;
      drive_idle();

      // T1: streaming fetch, memory with fixed one-cycle latency
      do_reset();
      ibus_ready = 1'b1;
      next_addr  = 32'h0;
      pend       = 1'b0;
      pend_addr  = '0;
      delivered  = 0;
      for (int cyc = 0; cyc < 40 && delivered < 6; cyc++) begin
         rsp(pend, pend ? mdata(pend_addr) : 32'h0);
         cmd(1'b1, next_addr);
         settle();
         if (cyc == 0) begin
            check("t1_nxt_reset", ibus_out_id_nxt, 32'hFFFF_FFFC);
            check("t1_reset_valid", 32'(ibus_valid), 32'h0);
         end
         if (cyc == 1) check("t1_nxt_first", ibus_out_id_nxt, 32'h0);
         if (cyc == 2) begin
            check("t1_full_stall", 32'(ibus_cmd_ready), 32'h0);
            check("t1_first_valid", 32'(ibus_valid), 32'h1);
         end
         if (ibus_valid) begin
            if (exp_q.size() == 0) begin
               check("t1_spurious_valid", 32'(ibus_valid), 32'h0);
            end else begin
               a = exp_q.pop_front();
               check("t1_out_id", ibus_out_id, a);
               check("t1_dout", ibus_dout, mdata(a));
               delivered++;
            end
         end
         pend      = ibus_cmd_valid && ibus_cmd_ready;
         pend_addr = next_addr;
         if (pend) begin
            exp_q.push_back(next_addr);
            next_addr = next_addr + 32'h4;
         end
         cycle();
      end
      check("t1_delivered", 32'(delivered), 32'd6);
      exp_q.delete();

      // T2: backpressure stalls the third cmd
      do_reset();
      cmd(1'b1, 32'h40); settle(); cycle();
      cmd(1'b1, 32'h44); rsp(1'b1, mdata(32'h40)); settle(); cycle();
      cmd(1'b1, 32'h48); rsp(1'b1, mdata(32'h44)); settle();
      check("t2_c2_cmd_ready", 32'(ibus_cmd_ready), 32'h0);
      check("t2_c2_mem_valid", 32'(mem_cmd_valid), 32'h0);
      check("t2_c2_out_id", ibus_out_id, 32'h40);
      cycle();
      rsp(1'b0, 32'h0); ibus_ready = 1'b1; settle();
      check("t2_c3_cmd_ready", 32'(ibus_cmd_ready), 32'h0);
      check("t2_c3_valid", 32'(ibus_valid), 32'h1);
      cycle();
      settle();
      check("t2_c4_cmd_ready", 32'(ibus_cmd_ready), 32'h1);
      check("t2_c4_out_id", ibus_out_id, 32'h44);
      check("t2_c4_dout", ibus_dout, mdata(32'h44));
      cycle();
      cmd(1'b0, 32'h0); rsp(1'b1, mdata(32'h48)); settle();
      check("t2_c5_valid", 32'(ibus_valid), 32'h0);
      cycle();
      rsp(1'b0, 32'h0); settle();
      check("t2_c6_out_id", ibus_out_id, 32'h48);
      check("t2_c6_dout", ibus_dout, mdata(32'h48));

      // T3: flush with two fetches still at memory
      do_reset();
      ibus_ready = 1'b1;
      cmd(1'b1, 32'h10); settle(); cycle();
      cmd(1'b1, 32'h14); settle(); cycle();
      cmd(1'b1, 32'h100); ibus_flush_req = 1'b1; settle();
      check("t3_c2_cmd_ready", 32'(ibus_cmd_ready), 32'h0);
      cycle();
      ibus_flush_req = 1'b0; rsp(1'b1, mdata(32'h10)); settle();
      check("t3_c3_cmd_ready", 32'(ibus_cmd_ready), 32'h0);
      check("t3_c3_valid", 32'(ibus_valid), 32'h0);
      cycle();
      rsp(1'b1, mdata(32'h14)); settle();
      check("t3_c4_cmd_ready", 32'(ibus_cmd_ready), 32'h1);
      check("t3_c4_valid", 32'(ibus_valid), 32'h0);
      cycle();
      cmd(1'b0, 32'h0); rsp(1'b1, mdata(32'h100)); settle();
      check("t3_c5_valid", 32'(ibus_valid), 32'h0);
      check("t3_c5_nxt", ibus_out_id_nxt, 32'h100);
      cycle();
      rsp(1'b0, 32'h0); settle();
      check("t3_c6_valid", 32'(ibus_valid), 32'h1);
      check("t3_c6_out_id", ibus_out_id, 32'h100);
      check("t3_c6_dout", ibus_dout, mdata(32'h100));

      // T4: flush in the cycle the first response lands
      do_reset();
      ibus_ready = 1'b1;
      cmd(1'b1, 32'h10); settle(); cycle();
      cmd(1'b1, 32'h14); settle(); cycle();
      cmd(1'b1, 32'h100); ibus_flush_req = 1'b1; rsp(1'b1, mdata(32'h10)); settle();
      check("t4_c2_cmd_ready", 32'(ibus_cmd_ready), 32'h0);
      cycle();
      ibus_flush_req = 1'b0; rsp(1'b1, mdata(32'h14)); settle();
      check("t4_c3_cmd_ready", 32'(ibus_cmd_ready), 32'h1);
      check("t4_c3_valid", 32'(ibus_valid), 32'h0);
      cycle();
      cmd(1'b0, 32'h0); rsp(1'b1, mdata(32'h100)); settle();
      check("t4_c4_valid", 32'(ibus_valid), 32'h0);
      cycle();
      rsp(1'b0, 32'h0); settle();
      check("t4_c5_valid", 32'(ibus_valid), 32'h1);
      check("t4_c5_out_id", ibus_out_id, 32'h100);
      check("t4_c5_dout", ibus_dout, mdata(32'h100));

      // T5: output handshake coincident with flush
      do_reset();
      cmd(1'b1, 32'h20); settle(); cycle();
      cmd(1'b1, 32'h24); rsp(1'b1, mdata(32'h20)); settle(); cycle();
      cmd(1'b0, 32'h0); rsp(1'b1, mdata(32'h24)); settle();
      check("t5_c2_out_id", ibus_out_id, 32'h20);
      cycle();
      rsp(1'b0, 32'h0); ibus_ready = 1'b1; ibus_flush_req = 1'b1; settle();
      check("t5_c3_valid", 32'(ibus_valid), 32'h1);
      check("t5_c3_out_id", ibus_out_id, 32'h20);
      check("t5_c3_dout", ibus_dout, mdata(32'h20));
      cycle();
      ibus_flush_req = 1'b0; cmd(1'b1, 32'h30); settle();
      check("t5_c4_valid", 32'(ibus_valid), 32'h0);
      check("t5_c4_cmd_ready", 32'(ibus_cmd_ready), 32'h1);
      cycle();
      cmd(1'b0, 32'h0); rsp(1'b1, mdata(32'h30)); settle();
      check("t5_c5_valid", 32'(ibus_valid), 32'h0);
      cycle();
      rsp(1'b0, 32'h0); settle();
      check("t5_c6_out_id", ibus_out_id, 32'h30);
      check("t5_c6_dout", ibus_dout, mdata(32'h30));

      // T6: reset with two entries outstanding, then a stray response
      do_reset();
      cmd(1'b1, 32'h50); settle(); cycle();
      cmd(1'b1, 32'h54); rsp(1'b1, mdata(32'h50)); settle(); cycle();
      cmd(1'b0, 32'h0); rsp(1'b0, 32'h0); settle();
      check("t6_pre_out_id", ibus_out_id, 32'h50);
      check("t6_pre_nxt", ibus_out_id_nxt, 32'h54);
      rst = 1'b1;
      cycle();
      rst = 1'b0; rsp(1'b1, 32'hDEAD_BEEF); settle();
      check("t6_rst_valid", 32'(ibus_valid), 32'h0);
      check("t6_rst_out_id", ibus_out_id, 32'h0);
      check("t6_rst_dout", ibus_dout, 32'h0);
      check("t6_rst_nxt", ibus_out_id_nxt, 32'hFFFF_FFFC);
      check("t6_rst_cmd_ready", 32'(ibus_cmd_ready), 32'h1);
      check("t6_rst_mem_valid", 32'(mem_cmd_valid), 32'h0);
      cycle();
      rsp(1'b0, 32'h0); settle();
      check("t6_stray_valid", 32'(ibus_valid), 32'h0);
      check("t6_stray_dout", ibus_dout, 32'h0);
      cycle();

      // report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
